// File: rtl/display_pkg.sv
// Shared constants for the seven-segment tube scanner:
// hex glyph table, active-low levels and scanner FSM states.
package display_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [7:0] ALL_OFF = 8'hFF;

  // Active-high g..a glyphs for hex digits 0..F
  localparam logic [6:0] SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high
// seven-segment (g..a) decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7[i_nib];

endmodule

// File: rtl/digital_tube_scanner.sv
// Eight-digit multiplexed seven-segment driver with
// inter-digit blanking and optional leading-zero blanking.
module digital_tube_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        iFpgaClk,
  input  logic        iFpgaRst,
  input  logic        iWrEn,
  input  logic [31:0] iWrData,
  input  logic [7:0]  iDpMask,
  input  logic        iZeroSuppress,
  output logic [7:0]  oDigitalTubeNotEnable,
  output logic [7:0]  oDigitalTubeShape
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [31:0]   rValue;
  logic [CW-1:0] rCnt;
  logic [2:0]    rDigit;
  state_t        rState;

  state_t        w_state_nxt;
  logic          w_cnt_end;
  logic          w_blank_end;
  logic [4:0]    w_shift;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_raw;
  logic [6:0]    w_seg;
  logic          w_suppress;
  logic [7:0]    w_en_nxt;
  logic [7:0]    w_shape_nxt;

  assign w_cnt_end   = rCnt == CW'(SCAN_DIV - 1);
  assign w_blank_end = rCnt == CW'(BLANK_CYCLES - 1);
  assign w_shift     = {rDigit, 2'b00};
  assign w_nib       = rValue[w_shift +: 4];

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg_raw)
  );

  // Blank this digit when it and every higher nibble are zero
  assign w_suppress = iZeroSuppress
                   && (rDigit != 3'd0)
                   && ((rValue >> w_shift) == 32'd0);
  assign w_seg = w_suppress ? 7'h00 : w_seg_raw;

  always_comb begin
    w_state_nxt = rState;
    w_en_nxt    = ALL_OFF;
    w_shape_nxt = ALL_OFF;
    unique case (rState)
      S_BLANK: if (w_blank_end) w_state_nxt = S_DRIVE;
      S_DRIVE: if (w_cnt_end)   w_state_nxt = S_BLANK;
    endcase
    // Outputs follow the next state so pins and state move together
    if (w_state_nxt == S_DRIVE) begin
      w_en_nxt    = ~(8'h01 << rDigit);
      w_shape_nxt = ~{iDpMask[rDigit], w_seg};
    end
  end

  always_ff @(posedge iFpgaClk) begin
    if (iFpgaRst) begin
      rValue                <= 32'd0;
      rCnt                  <= '0;
      rDigit                <= 3'd0;
      rState                <= S_BLANK;
      oDigitalTubeNotEnable <= ALL_OFF;
      oDigitalTubeShape     <= ALL_OFF;
    end else begin
      if (iWrEn) rValue <= iWrData;
      rCnt   <= w_cnt_end ? '0 : rCnt + CW'(1);
      rDigit <= rDigit + 3'(w_cnt_end);
      rState <= w_state_nxt;
      oDigitalTubeNotEnable <= w_en_nxt;
      oDigitalTubeShape     <= w_shape_nxt;
    end
  end

endmodule

// File: tb/tb_digital_tube_scanner.sv
// Scoreboard bench for digital_tube_scanner with
// SCAN_DIV = 8 and BLANK_CYCLES = 2.
module tb_digital_tube_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [7:0]  dp = 8'h00;
  logic        zs = 1'b0;
  logic [7:0]  nen;
  logic [7:0]  shp;

  digital_tube_scanner #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .iFpgaClk              (clk),
    .iFpgaRst              (rst),
    .iWrEn                 (wren),
    .iWrData               (wdata),
    .iDpMask               (dp),
    .iZeroSuppress         (zs),
    .oDigitalTubeNotEnable (nen),
    .oDigitalTubeShape     (shp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    int         id;
    logic [7:0] en;
    logic [7:0] sh;
  } exp_t;

  exp_t q[$];
  int   g = 0;
  int   base = 0;
  int   sc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge clk) g <= g + 1;

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].t <= g) begin
        nvec++;
        if (q[i].t < g || nen !== q[i].en || shp !== q[i].sh) begin
          nerr++;
          $display("FAIL s%0d_c%0d: en got %h want %h, shape got %h want %h",
                   q[i].id / 100, q[i].id % 100, nen, q[i].en, shp, q[i].sh);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input logic [7:0] en,
                           input logic [7:0] sh);
    exp_t e;
    e.t  = base + c;
    e.id = sc * 100 + c;
    e.en = en;
    e.sh = sh;
    q.push_back(e);
  endtask

  task automatic do_reset(input logic wr, input logic [31:0] d);
    exp_t e;
    rst   = 1'b1;
    wren  = wr;
    wdata = d;
    e.t  = g + 1;
    e.id = sc * 100 + 99;
    e.en = 8'hFF;
    e.sh = 8'hFF;
    q.push_back(e);
    @(negedge clk);
    rst  = 1'b0;
    wren = 1'b0;
    base = g;
  endtask

  task automatic wait_to(input int c);
    while (g < base + c) @(negedge clk);
  endtask

  task automatic write(input logic [31:0] d);
    wren  = 1'b1;
    wdata = d;
    @(negedge clk);
    wren  = 1'b0;
  endtask

  function automatic logic [7:0] en_of(input int k);
    return ~(8'(8'h01 << k));
  endfunction

  logic [7:0] t_hex [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6,
                            8'h83, 8'h88, 8'h90, 8'h80};
  logic [7:0] t_zs  [8] = '{8'hC0, 8'hA4, 8'hF9, 8'hFF,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] t_z0  [8] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] t_dp  [8] = '{8'hF9, 8'hC0, 8'h40, 8'hC0,
                            8'hC0, 8'hC0, 8'hC0, 8'hC0};
  logic [7:0] t_dpz [8] = '{8'hF9, 8'hFF, 8'h7F, 8'hFF,
                            8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    int waitn;
    @(negedge clk);

    sc = 1;
    do_reset(1'b0, 32'd0);
    expect_at(1, 8'hFF, 8'hFF);
    expect_at(2, 8'hFE, 8'hC0);
    expect_at(7, 8'hFE, 8'hC0);
    expect_at(8, 8'hFF, 8'hFF);
    expect_at(9, 8'hFF, 8'hFF);
    expect_at(10, 8'hFD, 8'hC0);
    wait_to(2);
    nvec++;
    if (nen !== 8'hFE || shp !== 8'hC0) begin
      nerr++;
      $display("FAIL s1 direct c2: en %h shape %h", nen, shp);
    end
    wait_to(8);
    nvec++;
    if (nen !== 8'hFF || shp !== 8'hFF) begin
      nerr++;
      $display("FAIL s1 direct c8: en %h shape %h", nen, shp);
    end
    wait_to(10);
    nvec++;
    if (nen !== 8'hFD) begin
      nerr++;
      $display("FAIL s1 direct c10: en %h", nen);
    end
    wait_to(12);

    sc = 2;
    do_reset(1'b0, 32'd0);
    expect_at(1, 8'hFF, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      expect_at(8 * k + 2, en_of(k), t_hex[k]);
      expect_at(8 * k + 7, en_of(k), t_hex[k]);
      expect_at(8 * k + 8, 8'hFF, 8'hFF);
    end
    write(32'h89AB_CDEF);
    wait_to(66);

    sc = 3;
    zs = 1'b1;
    do_reset(1'b0, 32'd0);
    for (int k = 0; k < 8; k++) begin
      expect_at(8 * k + 2, en_of(k), t_zs[k]);
      expect_at(8 * k + 5, en_of(k), t_zs[k]);
    end
    write(32'h0000_0120);
    wait_to(66);

    sc = 4;
    do_reset(1'b0, 32'd0);
    for (int k = 0; k < 8; k++)
      expect_at(8 * k + 4, en_of(k), t_z0[k]);
    wait_to(66);

    sc = 5;
    zs = 1'b0;
    dp = 8'h04;
    do_reset(1'b0, 32'd0);
    for (int k = 0; k < 8; k++)
      expect_at(8 * k + 3, en_of(k), t_dp[k]);
    write(32'h1);
    wait_to(66);

    sc = 6;
    zs = 1'b1;
    do_reset(1'b0, 32'd0);
    for (int k = 0; k < 8; k++)
      expect_at(8 * k + 3, en_of(k), t_dpz[k]);
    write(32'h1);
    wait_to(66);

    sc = 7;
    zs = 1'b0;
    dp = 8'h00;
    do_reset(1'b0, 32'd0);
    expect_at(3, 8'hFE, 8'hC0);
    expect_at(4, 8'hFE, 8'hC0);
    expect_at(5, 8'hFE, 8'h92);
    expect_at(7, 8'hFE, 8'h92);
    expect_at(8, 8'hFF, 8'hFF);
    expect_at(10, 8'hFD, 8'hC0);
    wait_to(3);
    write(32'h5);
    wait_to(5);
    nvec++;
    if (nen !== 8'hFE || shp !== 8'h92) begin
      nerr++;
      $display("FAIL s7 direct c5: en %h shape %h", nen, shp);
    end
    wait_to(12);

    sc = 8;
    do_reset(1'b0, 32'd0);
    expect_at(42, 8'hDF, 8'hB0);
    expect_at(43, 8'hDF, 8'hB0);
    write(32'h1234_5678);
    wait_to(43);
    do_reset(1'b1, 32'hFFFF_FFFF);
    expect_at(1, 8'hFF, 8'hFF);
    expect_at(2, 8'hFE, 8'hC0);
    expect_at(7, 8'hFE, 8'hC0);
    expect_at(8, 8'hFF, 8'hFF);
    expect_at(10, 8'hFD, 8'hC0);
    wait_to(2);
    nvec++;
    if (nen !== 8'hFE || shp !== 8'hC0) begin
      nerr++;
      $display("FAIL s8 direct c2: en %h shape %h", nen, shp);
    end
    wait_to(12);

    waitn = 0;
    while (q.size() > 0 && waitn < 200) begin
      @(negedge clk);
      waitn++;
    end
    foreach (q[i]) begin
      nvec++;
      nerr++;
      $display("FAIL timeout s%0d_c%0d: never checked, want en %h shape %h",
               q[i].id / 100, q[i].id % 100, q[i].en, q[i].sh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
